// File: rtl/alu_arbiter_if.sv
// Requester-side channel of the shared ALU arbiter: an operation request with
// valid/ready, plus the matching result response with valid/ready.
interface alu_req_if #(parameter int XLEN = 32);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [1:0]      aluop;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      shamt;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero;
    logic            rsp_less;

    modport master (
        output valid, a, b, aluop, funct3, funct7, shamt, rsp_ready,
        input  ready, rsp_valid, rsp_result, rsp_zero, rsp_less
    );

    modport slave (
        input  valid, a, b, aluop, funct3, funct7, shamt, rsp_ready,
        output ready, rsp_valid, rsp_result, rsp_zero, rsp_less
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU:
// grant, register operands, capture the ALU result, return it with valid/ready.
module alu_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_req_if.slave         req0,
    alu_req_if.slave         req1,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [1:0]       alu_aluop,
    output logic [2:0]       alu_funct3,
    output logic [6:0]       alu_funct7,
    output logic [4:0]       alu_shamt,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    input  logic             alu_less,
    output logic             busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [1:0]      aluop;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      shamt;
    } op_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            less;
    } rsp_t;

    state_t     state_q, state_d;
    op_t        op_q, op0, op1;
    rsp_t       rsp_q;
    logic       last_grant;
    logic       gnt, accept, done, rsp_rdy;
    logic [1:0] vld, rdy;

    assign op0 = {req0.a, req0.b, req0.aluop, req0.funct3, req0.funct7, req0.shamt};
    assign op1 = {req1.a, req1.b, req1.aluop, req1.funct3, req1.funct7, req1.shamt};
    assign vld = {req1.valid, req0.valid};
    assign rsp_rdy = grant_id ? req1.rsp_ready : req0.rsp_ready;

    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
        rdy     = 2'b00;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is suppressed while reset is held so nothing handshakes into a reset edge.
                if (rst_n && (vld != 2'b00)) begin
                    if (vld == 2'b01)          gnt = 1'b0;
                    else if (vld == 2'b10)     gnt = 1'b1;
                    else if (FIXED_PRIO != 0)  gnt = 1'b0;
                    else                       gnt = ~last_grant;
                    rdy     = gnt ? 2'b10 : 2'b01;
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_rdy) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rsp_q      <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            op_count   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= gnt ? op1 : op0;
                grant_id   <= gnt;
                last_grant <= gnt;
            end
            if (state_q == EXEC)
                rsp_q <= {alu_result, alu_zero, alu_less};
            if (done && (op_count != '1))
                op_count <= op_count + 1'b1;
        end
    end

    assign {alu_a, alu_b, alu_aluop, alu_funct3, alu_funct7, alu_shamt} = op_q;
    assign busy = (state_q != IDLE);

    assign req0.ready      = rdy[0];
    assign req1.ready      = rdy[1];
    assign req0.rsp_valid  = (state_q == RESP) && !grant_id;
    assign req1.rsp_valid  = (state_q == RESP) &&  grant_id;
    assign req0.rsp_result = rsp_q.result;
    assign req0.rsp_zero   = rsp_q.zero;
    assign req0.rsp_less   = rsp_q.less;
    assign req1.rsp_result = rsp_q.result;
    assign req1.rsp_zero   = rsp_q.zero;
    assign req1.rsp_less   = rsp_q.less;
endmodule
